// File: rtl/register_file.sv
// 2**ADDR_W x DATA_W register file: two combinational read ports, one write port, r0 hardwired to 0.
// Optional write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] RA1,
    input  logic [ADDR_W-1:0] RA2,
    input  logic [ADDR_W-1:0] WA,
    input  logic [DATA_W-1:0] WD,
    input  logic              RegWrite,
    output logic [DATA_W-1:0] DR1,
    output logic [DATA_W-1:0] DR2
);
    localparam int DEPTH   = 2**ADDR_W;
    localparam int NUM_RD  = 2;

    logic [DEPTH-1:0][DATA_W-1:0]  regs;
    logic [NUM_RD-1:0][ADDR_W-1:0] ra;
    logic [NUM_RD-1:0][DATA_W-1:0] dr;
    logic                          wr_en;

    // r0 is never written, so it stays at its reset value of 0.
    assign wr_en = RegWrite && (WA != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            regs <= '0;
        else if (wr_en)
            regs[WA] <= WD;
    end

    assign ra  = {RA2, RA1};
    assign DR1 = dr[0];
    assign DR2 = dr[1];

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic fwd;
`ifdef REGFILE_BYPASS_EN
        assign fwd = wr_en && (ra[p] == WA);
`else
        assign fwd = 1'b0;
`endif
        // Reset and address 0 take priority over forwarding.
        assign dr[p] = (reset || ra[p] == '0) ? '0 :
                       fwd                    ? WD :
                                                regs[ra[p]];
    end
endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus randomized traffic against an array model.
module tb_register_file;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 2**ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] RA1, RA2, WA;
    logic [DATA_W-1:0] WD;
    logic              RegWrite;
    logic [DATA_W-1:0] DR1, DR2;

    logic [DATA_W-1:0] model [DEPTH];
    int passed = 0;
    int total  = 0;

    register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .RA1(RA1), .RA2(RA2), .WA(WA), .WD(WD),
        .RegWrite(RegWrite), .DR1(DR1), .DR2(DR2)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] exp_read(input logic [ADDR_W-1:0] a);
        if (reset || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (RegWrite && WA != 0 && a == WA) return WD;
`endif
        return model[a];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    task automatic tick();
        if (!reset && RegWrite && WA != 0) model[WA] = WD;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        WA = a; WD = d; RegWrite = 1'b1;
        tick();
        RegWrite = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; RegWrite = 1'b1; WA = 5'd7; WD = 32'hA5A5A5A5;
        RA1 = 5'd7; RA2 = 5'd31;
        clear_model();
        #1;
        total++; if (DR1 !== 0 || DR2 !== 0) $display("FAIL reset_out DR1=%h DR2=%h need 0", DR1, DR2); else passed++;
        tick(); tick();
        RegWrite = 1'b0;
        reset = 1'b0;
        #1;
        total++; if (DR1 !== 0) $display("FAIL reset_ignore_write DR1=%h need 0", DR1); else passed++;
        wr(5'd5, 32'hDEADBEEF);
        RA1 = 5'd5; #1;
        total++; if (DR1 !== 32'hDEADBEEF) $display("FAIL pre_reset_r5 DR1=%h need deadbeef", DR1); else passed++;
        // Write to r6 in flight when reset asserts mid-cycle.
        WA = 5'd6; WD = 32'h12345678; RegWrite = 1'b1; RA2 = 5'd6;
        #2 reset = 1'b1;
        #1;
        total++; if (DR1 !== 0) $display("FAIL reset_async DR1=%h need 0", DR1); else passed++;
        tick();
        clear_model();
        RegWrite = 1'b0;
        reset = 1'b0;
        #1;
        total++; if (DR1 !== 0) $display("FAIL reset_after_r5 DR1=%h need 0", DR1); else passed++;
        total++; if (DR2 !== 0) $display("FAIL reset_discard_r6 DR2=%h need 0", DR2); else passed++;
        tick();
        total++; if (DR1 !== 0) $display("FAIL reset_stable DR1=%h need 0", DR1); else passed++;
    endtask

    task automatic test_write_read();
        wr(5'd3, 32'h00000007);
        RA1 = 5'd3; RA2 = 5'd3; #1;
        total++; if (DR1 !== 32'h7) $display("FAIL wr_rd_dr1 DR1=%h need 7", DR1); else passed++;
        total++; if (DR2 !== 32'h7) $display("FAIL wr_rd_dr2 DR2=%h need 7", DR2); else passed++;
    endtask

    task automatic test_zero_reg();
        wr(5'd0, 32'hFFFFFFFF);
        RA1 = 5'd0; RA2 = 5'd0; #1;
        total++; if (DR1 !== 0) $display("FAIL zero_reg DR1=%h need 0", DR1); else passed++;
        // Address 0 stays 0 even while being written with forwarding enabled.
        WA = 5'd0; WD = 32'hCAFEF00D; RegWrite = 1'b1; #1;
        total++; if (DR2 !== 0) $display("FAIL zero_fwd DR2=%h need 0", DR2); else passed++;
        RegWrite = 1'b0;
    endtask

    task automatic test_forward();
        logic [DATA_W-1:0] pre_exp;
        wr(5'd9, 32'h11);
        WA = 5'd9; WD = 32'h22; RegWrite = 1'b1; RA2 = 5'd9; #1;
`ifdef REGFILE_BYPASS_EN
        pre_exp = 32'h22;
`else
        pre_exp = 32'h11;
`endif
        total++; if (DR2 !== pre_exp) $display("FAIL fwd_pre DR2=%h need %h", DR2, pre_exp); else passed++;
        tick();
        RegWrite = 1'b0; #1;
        total++; if (DR2 !== 32'h22) $display("FAIL fwd_post DR2=%h need 22", DR2); else passed++;
    endtask

    task automatic test_write_disable();
        wr(5'd4, 32'h10);
        WA = 5'd4; WD = 32'h99; RegWrite = 1'b0; RA1 = 5'd4;
        tick();
        total++; if (DR1 !== 32'h10) $display("FAIL wr_disable DR1=%h need 10", DR1); else passed++;
    endtask

    task automatic test_sweep();
        int errs = 0;
        for (int n = 1; n < DEPTH; n++) wr(n[ADDR_W-1:0], n);
        for (int n = 0; n < DEPTH; n++) begin
            RA1 = n[ADDR_W-1:0]; RA2 = n[ADDR_W-1:0]; #1;
            total++;
            if (DR1 !== n || DR2 !== n) begin
                $display("FAIL sweep r%0d DR1=%h DR2=%h need %h", n, DR1, DR2, n);
                errs++;
            end else passed++;
        end
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] e1, e2;
        for (int i = 0; i < 300; i++) begin
            WA = $urandom_range(DEPTH-1); WD = $urandom; RegWrite = $urandom_range(1);
            RA1 = ($urandom_range(3) == 0) ? WA : ADDR_W'($urandom_range(DEPTH-1));
            RA2 = ($urandom_range(3) == 0) ? RA1 : ADDR_W'($urandom_range(DEPTH-1));
            #1;
            e1 = exp_read(RA1); e2 = exp_read(RA2);
            total++;
            if (DR1 !== e1 || DR2 !== e2)
                $display("FAIL rand_pre[%0d] RA1=%0d DR1=%h need %h RA2=%0d DR2=%h need %h", i, RA1, DR1, e1, RA2, DR2, e2);
            else passed++;
            tick();
            RegWrite = 1'b0; #1;
            e1 = exp_read(RA1); e2 = exp_read(RA2);
            total++;
            if (DR1 !== e1 || DR2 !== e2)
                $display("FAIL rand_post[%0d] RA1=%0d DR1=%h need %h RA2=%0d DR2=%h need %h", i, RA1, DR1, e1, RA2, DR2, e2);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_zero_reg();
        test_forward();
        test_write_disable();
        test_sweep();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register and data-port width.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width; depth = 2**ADDR_W (32).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port RA1  input  ADDR_W  read address, port 1.
REQ-006 SHALL have port RA2  input  ADDR_W  read address, port 2.
REQ-007 SHALL have port WA  input  ADDR_W  write address.
REQ-008 SHALL have port WD  input  DATA_W  write data.
REQ-009 SHALL have port RegWrite  input  1  write enable.
REQ-010 SHALL have port DR1  output  DATA_W  read data, port 1; drives the ALU DR1 operand.
REQ-011 SHALL have port DR2  output  DATA_W  read data, port 2; drives the ALU DR2 operand.

Function
REQ-012 SHALL hold 2**ADDR_W registers of DATA_W bits.
REQ-013 SHALL update register[WA] to WD on a rising clk edge when RegWrite=1, WA!=0 and reset=0.
REQ-014 SHALL leave every register unchanged on an edge when RegWrite=0.
REQ-015 SHALL hardwire register 0: writes to WA=0 are discarded; reads of address 0 return 0.
REQ-016 SHALL produce DR1/DR2 combinationally from RA1/RA2 and the current contents, with zero-cycle latency.
REQ-017 SHALL permit RA1==RA2; both ports then return identical data.
REQ-018 SHALL perform at most one write per cycle; the write port and both read ports are independent.
REQ-019 SHALL keep written data stable indefinitely until overwritten or reset.
REQ-020 SHALL avoid X on DR1/DR2 for any known address after reset.

Reset
REQ-021 SHALL clear all registers to 0 immediately on reset assertion, without waiting for clk.
REQ-022 SHALL drive DR1=0 and DR2=0 while reset=1, whatever the addresses.
REQ-023 SHALL ignore RegWrite while reset=1, including on the edge where reset deasserts.
REQ-024 SHALL discard a write in progress when reset asserts mid-cycle; the register reads 0 afterwards.

Configuration
REQ-025 SHALL use macro REGFILE_BYPASS_EN to select write-to-read forwarding.
REQ-026 With REGFILE_BYPASS_EN defined: when RegWrite=1, WA!=0 and RAn==WA, DRn SHALL equal WD in the same cycle, before the edge.
REQ-027 Without REGFILE_BYPASS_EN: DRn SHALL return the pre-write contents until the edge, then the new value.
REQ-028 In both modes, reads of address 0 SHALL return 0, and reset SHALL take priority over forwarding.

Verification
REQ-029 Reset check: write 0xDEADBEEF to r5, assert reset -> DR1 (RA1=5) = 0 within the same cycle; after deassertion DR1 remains 0.
REQ-030 Write/read check: WA=3, WD=0x00000007, RegWrite=1, edge; then RA1=3, RA2=3 -> DR1=DR2=0x00000007.
REQ-031 Zero-register check: WA=0, WD=0xFFFFFFFF, RegWrite=1, edge; RA1=0 -> DR1=0.
REQ-032 Forwarding check: r9=0x11; same cycle WA=9, WD=0x22, RegWrite=1, RA2=9 -> before the edge, DR2=0x22 with REGFILE_BYPASS_EN and 0x11 without; after the edge, 0x22 in both builds.
REQ-033 Write-disable check: r4=0x10; WA=4, WD=0x99, RegWrite=0, edge -> DR1 (RA1=4) = 0x10.
REQ-034 Sweep check: write address value n to r1..r31, read back on both ports -> DRn = n for every address; r0 = 0.
